// File: rtl/fma16_vec_runner.sv
// fma16_vec_runner
//   Replays test vectors from a synchronous ROM into one combinational fma16
//   instance and checks each result against the expected value in the vector.
//   Reports the number of failing vectors and the index of the first failure.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   start           1-cycle pulse starting a run (ignored while busy)
//   num_vec         vectors to run, clamped to 2**ADDR_W, sampled on accepted start
//   rom_addr        ROM read address (ROM answers one cycle later on rom_data)
//   rom_data        {x[71:56], y[55:40], z[39:24], ctrl[23:16], exp[15:0]}
//   fma_x/y/z       registered operands to fma16
//   fma_mul/add     ctrl[0], ctrl[1]
//   fma_negr/negz   ctrl[2], ctrl[3]
//   fma_roundmode   ctrl[5:4]
//   fma_result      fma16 result, combinational from the fma_* outputs
//   busy, done      run in progress / run finished (held until restart)
//   err_count       failing vectors in this run
//   first_err_idx   index of the first failing vector, valid with first_err_vld
module fma16_vec_runner #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [71:0]       rom_data,
    output logic [15:0]       fma_x,
    output logic [15:0]       fma_y,
    output logic [15:0]       fma_z,
    output logic              fma_mul,
    output logic              fma_add,
    output logic              fma_negr,
    output logic              fma_negz,
    output logic [1:0]        fma_roundmode,
    input  logic [15:0]       fma_result,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   err_count,
    output logic [ADDR_W-1:0] first_err_idx,
    output logic              first_err_vld
);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOAD, S_CHECK, S_DONE} state_t;

    localparam logic [ADDR_W:0]   MAX_VEC = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic                empty_pend_q, empty_pend_d;
    logic [ADDR_W-1:0]   rom_addr_q, rom_addr_d;
    logic [15:0]         fma_x_q, fma_x_d, fma_y_q, fma_y_d, fma_z_q, fma_z_d;
    logic [5:0]          ctrl_q, ctrl_d;
    logic                nan_acc_q, nan_acc_d, skip_q, skip_d;
    logic [15:0]         exp_q, exp_d;
    logic                busy_q, busy_d, done_q, done_d;
    logic [ADDR_W:0]     err_count_q, err_count_d;
    logic [ADDR_W-1:0]   first_err_idx_q, first_err_idx_d;
    logic                first_err_vld_q, first_err_vld_d;
    logic                accept;
    logic [ADDR_W:0]     n_clamp;

    // Pass/fail rule for one vector: skip always passes, NaN-accept passes on
    // any NaN encoding (either sign), otherwise an exact 16-bit match is needed.
    function automatic logic vec_pass(input logic [15:0] res, input logic [15:0] expv,
                                      input logic nan_acc, input logic skip);
        if (skip) return 1'b1;
        if (nan_acc) return (res[14:10] == 5'h1F) && (res[9:0] != 10'd0);
        return res == expv;
    endfunction

    assign n_clamp = (num_vec > MAX_VEC) ? MAX_VEC : num_vec;

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        n_d             = n_q;
        empty_pend_d    = empty_pend_q;
        rom_addr_d      = rom_addr_q;
        fma_x_d         = fma_x_q;
        fma_y_d         = fma_y_q;
        fma_z_d         = fma_z_q;
        ctrl_d          = ctrl_q;
        nan_acc_d       = nan_acc_q;
        skip_d          = skip_q;
        exp_d           = exp_q;
        busy_d          = busy_q;
        done_d          = done_q;
        err_count_d     = err_count_q;
        first_err_idx_d = first_err_idx_q;
        first_err_vld_d = first_err_vld_q;
        accept          = 1'b0;

        case (state_q)
            S_IDLE: begin
                // An empty run spends one idle cycle before reporting done,
                // and no new start is taken during that cycle.
                if (empty_pend_q) begin
                    empty_pend_d = 1'b0;
                    done_d       = 1'b1;
                    state_d      = S_DONE;
                end else begin
                    accept = start;
                end
            end
            S_DONE: accept = start;
            S_FETCH: state_d = S_LOAD;
            S_LOAD: begin
                fma_x_d   = rom_data[71:56];
                fma_y_d   = rom_data[55:40];
                fma_z_d   = rom_data[39:24];
                ctrl_d    = rom_data[21:16];
                nan_acc_d = rom_data[22];
                skip_d    = rom_data[23];
                exp_d     = rom_data[15:0];
                state_d   = S_CHECK;
            end
            S_CHECK: begin
                if (!vec_pass(fma_result, exp_q, nan_acc_q, skip_q)) begin
                    err_count_d = err_count_q + CNT_ONE;
                    if (!first_err_vld_q) begin
                        first_err_idx_d = idx_q;
                        first_err_vld_d = 1'b1;
                    end
                end
                if (({1'b0, idx_q} + CNT_ONE) == n_q) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d      = idx_q + IDX_ONE;
                    rom_addr_d = idx_q + IDX_ONE;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (accept) begin
            err_count_d     = '0;
            first_err_idx_d = '0;
            first_err_vld_d = 1'b0;
            done_d          = 1'b0;
            idx_d           = '0;
            n_d             = n_clamp;
            if (n_clamp == '0) begin
                empty_pend_d = 1'b1;
                state_d      = S_IDLE;
            end else begin
                busy_d     = 1'b1;
                rom_addr_d = '0;
                state_d    = S_FETCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            idx_q           <= '0;
            n_q             <= '0;
            empty_pend_q    <= 1'b0;
            rom_addr_q      <= '0;
            fma_x_q         <= '0;
            fma_y_q         <= '0;
            fma_z_q         <= '0;
            ctrl_q          <= '0;
            nan_acc_q       <= 1'b0;
            skip_q          <= 1'b0;
            exp_q           <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            err_count_q     <= '0;
            first_err_idx_q <= '0;
            first_err_vld_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            n_q             <= n_d;
            empty_pend_q    <= empty_pend_d;
            rom_addr_q      <= rom_addr_d;
            fma_x_q         <= fma_x_d;
            fma_y_q         <= fma_y_d;
            fma_z_q         <= fma_z_d;
            ctrl_q          <= ctrl_d;
            nan_acc_q       <= nan_acc_d;
            skip_q          <= skip_d;
            exp_q           <= exp_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            err_count_q     <= err_count_d;
            first_err_idx_q <= first_err_idx_d;
            first_err_vld_q <= first_err_vld_d;
        end
    end

    assign rom_addr      = rom_addr_q;
    assign fma_x         = fma_x_q;
    assign fma_y         = fma_y_q;
    assign fma_z         = fma_z_q;
    assign fma_mul       = ctrl_q[0];
    assign fma_add       = ctrl_q[1];
    assign fma_negr      = ctrl_q[2];
    assign fma_negz      = ctrl_q[3];
    assign fma_roundmode = ctrl_q[5:4];
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_count_q;
    assign first_err_idx = first_err_idx_q;
    assign first_err_vld = first_err_vld_q;

endmodule
